// File: rtl/fp_add_normalizer_pkg.sv
// ============================================================================
//  Package     : fp_pkg
//  Description : Shared widths, limits and FSM state encoding for the
//                single-precision adder normalize/round stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  // Raw mantissa layout: {C, H, frac[FRAC_W-1:0], G, R, S}
  localparam int RAW_W    = FRAC_W + 5;
  localparam int RES_W    = 1 + EXP_W + FRAC_W;
  // Internal exponent carries two spare bits so increments never wrap
  localparam int XEXP_W   = EXP_W + 2;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = (1 << EXP_W) - 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_ROUND = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/fp_add_normalizer_rounder.sv
// ============================================================================
//  Module      : fp_rne_rounder
//  Description : Combinational round-to-nearest-even on {H,frac} using the
//                guard/round/sticky bits. Carry flags a mantissa overflow
//                out of the hidden bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_rne_rounder
  import fp_pkg::*;
(
  input  logic              i_h,
  input  logic [FRAC_W-1:0] i_frac,
  input  logic              i_g,
  input  logic              i_r,
  input  logic              i_s,
  output logic [FRAC_W:0]   o_mant,
  output logic              o_carry
);

  logic              w_inc;
  logic [FRAC_W+1:0] w_sum;

  // Round up when above halfway, or exactly halfway with an odd LSB
  assign w_inc   = i_g & (i_r | i_s | i_frac[0]);
  assign w_sum   = {1'b0, i_h, i_frac} + {{(FRAC_W+1){1'b0}}, w_inc};
  assign o_carry = w_sum[FRAC_W+1];
  assign o_mant  = w_sum[FRAC_W:0];

endmodule

`default_nettype wire

// File: rtl/fp_add_normalizer.sv
// ============================================================================
//  Module      : fp_add_normalizer
//  Description : Multi-cycle normalize-and-round stage behind the FP adder's
//                align/add datapath. One-bit-per-cycle left-shift FSM, RNE
//                rounding, packed IEEE-754 result on a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add_normalizer
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [RAW_W-1:0] in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_overflow,
  output logic             out_underflow
);

  localparam logic [XEXP_W-1:0] c_EXP_ONE = XEXP_W'(1);
  localparam logic [XEXP_W-1:0] c_EXP_SAT = XEXP_W'(EXP_MAX);

  logic [2:0]        r_state;
  logic              r_sign;
  logic [XEXP_W-1:0] r_exp;
  logic [RAW_W-1:0]  r_mant;
  logic [RES_W-1:0]  r_result;
  logic              r_ovf;
  logic              r_unf;

  logic              w_c;
  logic              w_h;
  logic              w_exp_is1;
  logic [RAW_W-1:0]  w_shl;
  logic [RAW_W-1:0]  w_shr;
  logic [XEXP_W-1:0] w_exp_dec;
  logic [FRAC_W:0]   w_rnd_mant;
  logic              w_rnd_carry;
  logic [XEXP_W-1:0] w_exp_rnd;
  logic [FRAC_W-1:0] w_frac_rnd;
  logic              w_h_rnd;
  logic              w_ovf;

  assign w_c       = r_mant[RAW_W-1];
  assign w_h       = r_mant[RAW_W-2];
  assign w_exp_is1 = (r_exp == c_EXP_ONE);

  // Left shift moves S->R->G->frac and clears S; right shift folds the
  // bit falling off the bottom into sticky so no information is lost.
  assign w_shl     = {r_mant[RAW_W-2:0], 1'b0};
  assign w_shr     = {1'b0, r_mant[RAW_W-1:2], r_mant[1] | r_mant[0]};
  assign w_exp_dec = r_exp - c_EXP_ONE;

  fp_rne_rounder u_rounder (
    .i_h     (r_mant[RAW_W-2]),
    .i_frac  (r_mant[RAW_W-3:3]),
    .i_g     (r_mant[2]),
    .i_r     (r_mant[1]),
    .i_s     (r_mant[0]),
    .o_mant  (w_rnd_mant),
    .o_carry (w_rnd_carry)
  );

  // A rounding carry renormalizes by one: mantissa becomes 1.000.., exp+1
  assign w_exp_rnd  = r_exp + {{(XEXP_W-1){1'b0}}, w_rnd_carry};
  assign w_frac_rnd = w_rnd_carry ? w_rnd_mant[FRAC_W:1] : w_rnd_mant[FRAC_W-1:0];
  assign w_h_rnd    = w_rnd_carry | w_rnd_mant[FRAC_W];
  assign w_ovf      = (w_exp_rnd >= c_EXP_SAT);

  // Control FSM plus datapath registers; result is latched on leaving ROUND
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign  <= in_sign;
            r_exp   <= {2'b00, in_exp};
            r_mant  <= in_mant;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_mant == '0) begin
            // Exact cancellation yields +0 regardless of raw sign
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_state  <= ST_DONE;
          end else if (w_c) begin
            r_mant  <= w_shr;
            r_exp   <= r_exp + c_EXP_ONE;
            r_state <= ST_ROUND;
          end else if (w_h || w_exp_is1) begin
            r_state <= ST_ROUND;
          end else begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_mant <= w_shl;
          r_exp  <= w_exp_dec;
          if (w_shl[RAW_W-2] || (w_exp_dec == c_EXP_ONE)) begin
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (w_ovf) begin
            r_result <= {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            r_ovf    <= 1'b1;
            r_unf    <= 1'b0;
          end else if (!w_h_rnd) begin
            // Still no hidden bit: denormal encoding with exponent field 0
            r_result <= {r_sign, {EXP_W{1'b0}}, w_frac_rnd};
            r_ovf    <= 1'b0;
            r_unf    <= 1'b1;
          end else begin
            r_result <= {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == ST_IDLE);
  assign out_valid     = (r_state == ST_DONE);
  assign out_result    = r_result;
  assign out_overflow  = r_ovf;
  assign out_underflow = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_normalizer.sv
// ============================================================================
//  Module      : tb_fp_add_normalizer
//  Description : Directed-vector bench for fp_add_normalizer with
//                hand-computed results, latencies and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_add_normalizer;
  import fp_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [RAW_W-1:0] in_mant;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic             out_overflow;
  logic             out_underflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_add_normalizer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  // Upstream never presents an all-ones exponent
  always @(posedge clk) begin
    if (in_valid) assert (in_exp != {EXP_W{1'b1}}) else $error("in_exp all-ones presented");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [RAW_W-1:0] mk(input logic c, input logic h,
                                          input logic [FRAC_W-1:0] f, input logic [2:0] grs);
    return {c, h, f, grs};
  endfunction

  // Apply one item, measure latency from the accept edge, check result and
  // flags, optionally stall out_ready for `hold` cycles, then drain.
  task automatic run_vec(input string tag, input logic s, input logic [EXP_W-1:0] e,
                         input logic [RAW_W-1:0] m, input logic [31:0] want,
                         input int lat_want, input logic ovf, input logic unf, input int hold);
    int lat;
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(lat_want));
    check_eq({tag, "_res"}, out_result, want);
    check_eq({tag, "_ovf"}, 32'(out_overflow), 32'(ovf));
    check_eq({tag, "_unf"}, 32'(out_underflow), 32'(unf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_res"}, out_result, want);
      check_eq({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_in_ready",  32'(in_ready),      32'd1);
    check_eq("rst_out_valid", 32'(out_valid),     32'd0);
    check_eq("rst_result",    out_result,         32'h0);
    check_eq("rst_ovf",       32'(out_overflow),  32'd0);
    check_eq("rst_unf",       32'(out_underflow), 32'd0);

    // Already normalized, plain carry-out, cancellation
    run_vec("t1_norm",   1'b0, 8'h82, mk(1'b0, 1'b1, 23'h010000, 3'b000), 32'h41010000, 2, 1'b0, 1'b0, 0);
    run_vec("t2_carry",  1'b0, 8'h81, mk(1'b1, 1'b1, 23'h000000, 3'b000), 32'h41400000, 2, 1'b0, 1'b0, 0);
    run_vec("t3_cancel", 1'b0, 8'h85, mk(1'b0, 1'b0, 23'h100000, 3'b000), 32'h41000000, 5, 1'b0, 1'b0, 0);

    // Round-to-nearest-even: halfway odd, halfway even, carry out of H
    run_vec("t4_rne_up",  1'b0, 8'h7F, mk(1'b0, 1'b1, 23'h000001, 3'b100), 32'h3F800002, 2, 1'b0, 1'b0, 0);
    run_vec("t4_rne_tie", 1'b0, 8'h7F, mk(1'b0, 1'b1, 23'h000000, 3'b100), 32'h3F800000, 2, 1'b0, 1'b0, 0);
    run_vec("t4_rne_cry", 1'b0, 8'h7F, mk(1'b0, 1'b1, 23'h7FFFFF, 3'b110), 32'h40000000, 2, 1'b0, 1'b0, 0);

    // Limits: overflow, denormal, zero, shift stopped by exponent floor
    run_vec("t5_ovf",    1'b0, 8'hFE, mk(1'b1, 1'b1, 23'h000000, 3'b000), 32'h7F800000, 2, 1'b1, 1'b0, 0);
    run_vec("t5_denorm", 1'b0, 8'h01, mk(1'b0, 1'b0, 23'h400000, 3'b000), 32'h00400000, 2, 1'b0, 1'b1, 0);
    run_vec("t5_zero",   1'b1, 8'h40, mk(1'b0, 1'b0, 23'h000000, 3'b000), 32'h00000000, 1, 1'b0, 1'b0, 0);
    run_vec("t5_floor",  1'b0, 8'h03, mk(1'b0, 1'b0, 23'h000100, 3'b000), 32'h00000400, 4, 1'b0, 1'b1, 0);

    // Back-pressure: result held for 10 cycles with in_ready low
    run_vec("t6_hold", 1'b1, 8'h82, mk(1'b0, 1'b1, 23'h010000, 3'b000), 32'hC1010000, 2, 1'b0, 1'b0, 10);

    // Reset during SHIFT abandons the item
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'h85;
    in_mant  = mk(1'b0, 1'b0, 23'h000001, 3'b000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_pre_rst_rdy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_rst_rdy", 32'(in_ready),  32'd1);
    check_eq("t6_rst_vld", 32'(out_valid), 32'd0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("t6_no_out", 32'(out_valid), 32'd0);

    run_vec("t6_after", 1'b0, 8'h85, mk(1'b0, 1'b0, 23'h100000, 3'b000), 32'h41000000, 5, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
